// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle control unit: state encoding, opcode/funct
// constants, ALU operation codes and datapath mux select codes.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StRtype   = 4'd2,
        StAluwbR  = 4'd3,
        StItype   = 4'd4,
        StAluwbI  = 4'd5,
        StMemadr  = 4'd6,
        StMemrd   = 4'd7,
        StMemwb   = 4'd8,
        StMemwr   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StHalt    = 4'd12,
        StIllegal = 4'd13
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnSra = 6'h03;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnXor = 6'h26;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluOr  = 4'd3;
    localparam logic [3:0] AluXor = 4'd4;
    localparam logic [3:0] AluNor = 4'd5;
    localparam logic [3:0] AluSlt = 4'd6;
    localparam logic [3:0] AluSll = 4'd7;
    localparam logic [3:0] AluSrl = 4'd8;
    localparam logic [3:0] AluSra = 4'd9;

    localparam logic [1:0] In1Pc    = 2'd0;
    localparam logic [1:0] In1A     = 2'd1;
    localparam logic [1:0] In1Shamt = 2'd2;
    localparam logic [1:0] In2B     = 2'd0;
    localparam logic [1:0] In2One   = 2'd1;
    localparam logic [1:0] In2Imm   = 2'd2;
    localparam logic [1:0] PcAlu    = 2'd0;
    localparam logic [1:0] PcAluReg = 2'd1;
    localparam logic [1:0] PcJump   = 2'd2;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU op, flags shifts (which take shamt on in1)
// and reports whether the funct is supported.
module mc_control_fsm_alu_decoder
    import mc_control_fsm_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_sel,
    output logic       shift,
    output logic       legal
);

    always_comb begin
        alu_sel = AluAdd;
        shift   = 1'b0;
        legal   = 1'b1;
        case (funct)
            FnAdd: alu_sel = AluAdd;
            FnSub: alu_sel = AluSub;
            FnAnd: alu_sel = AluAnd;
            FnOr:  alu_sel = AluOr;
            FnXor: alu_sel = AluXor;
            FnNor: alu_sel = AluNor;
            FnSlt: alu_sel = AluSlt;
            FnSll: begin alu_sel = AluSll; shift = 1'b1; end
            FnSrl: begin alu_sel = AluSrl; shift = 1'b1; end
            FnSra: begin alu_sel = AluSra; shift = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM driving the datapath enables and selects.
// Define CTRL_PERF_CNT_EN to add cycle_cnt/instr_cnt performance counters.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = 6'h3F
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       MWE,
    output logic       RFWE,
    output logic       PCE,
    output logic       IRWE,
    output logic [3:0] ALU_sel,
    output logic [1:0] ALU_in_sel1,
    output logic [1:0] ALU_in_sel2,
    output logic [1:0] PC_sel,
    output logic       ID_sel,
    output logic       M_to_RF_sel,
    output logic       RFD_sel,
    output logic       halted,
`ifdef CTRL_PERF_CNT_EN
    output logic       illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`else
    output logic       illegal
`endif
);

    state_e     state_q;
    logic [3:0] dec_alu_sel;
    logic       dec_shift;
    logic       dec_legal;

    mc_control_fsm_alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_sel (dec_alu_sel),
        .shift   (dec_shift),
        .legal   (dec_legal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
        end else begin
            case (state_q)
                StFetch:  state_q <= StDecode;
                StDecode: begin
                    case (opcode)
                        OpRtype:       state_q <= StRtype;
                        OpAddi, OpSlti: state_q <= StItype;
                        OpLw, OpSw:    state_q <= StMemadr;
                        OpBeq, OpBne:  state_q <= StBranch;
                        OpJ:           state_q <= StJump;
                        default:       state_q <= (opcode == HALT_OPCODE) ? StHalt : StIllegal;
                    endcase
                end
                StRtype:   state_q <= dec_legal ? StAluwbR : StIllegal;
                StItype:   state_q <= StAluwbI;
                StMemadr:  state_q <= (opcode == OpLw) ? StMemrd : StMemwr;
                StMemrd:   state_q <= StMemwb;
                StHalt:    state_q <= StHalt;
                StIllegal: state_q <= StIllegal;
                default:   state_q <= StFetch;
            endcase
        end
    end

    // Moore decode of the state register; reset masks everything so an aborted
    // instruction can never write.
    always_comb begin
        MWE         = 1'b0;
        RFWE        = 1'b0;
        PCE         = 1'b0;
        IRWE        = 1'b0;
        ALU_sel     = AluAdd;
        ALU_in_sel1 = In1Pc;
        ALU_in_sel2 = In2B;
        PC_sel      = PcAlu;
        ID_sel      = 1'b0;
        M_to_RF_sel = 1'b0;
        RFD_sel     = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        if (!RST) begin
            case (state_q)
                StFetch: begin
                    IRWE        = 1'b1;
                    PCE         = 1'b1;
                    ALU_in_sel2 = In2One;
                end
                StDecode: ALU_in_sel2 = In2Imm;
                StRtype: begin
                    ALU_in_sel1 = dec_shift ? In1Shamt : In1A;
                    ALU_sel     = dec_alu_sel;
                end
                StAluwbR: begin
                    RFWE    = 1'b1;
                    RFD_sel = 1'b1;
                end
                StItype: begin
                    ALU_in_sel1 = In1A;
                    ALU_in_sel2 = In2Imm;
                    ALU_sel     = (opcode == OpSlti) ? AluSlt : AluAdd;
                end
                StAluwbI: RFWE = 1'b1;
                StMemadr: begin
                    ALU_in_sel1 = In1A;
                    ALU_in_sel2 = In2Imm;
                end
                StMemrd: ID_sel = 1'b1;
                StMemwb: begin
                    RFWE        = 1'b1;
                    M_to_RF_sel = 1'b1;
                end
                StMemwr: begin
                    ID_sel = 1'b1;
                    MWE    = 1'b1;
                end
                StBranch: begin
                    ALU_in_sel1 = In1A;
                    ALU_sel     = AluSub;
                    PC_sel      = PcAluReg;
                    // Only Mealy output: the compare result decides the PC write.
                    PCE         = (opcode == OpBne) ? ~zero : zero;
                end
                StJump: begin
                    PC_sel = PcJump;
                    PCE    = 1'b1;
                end
                StHalt:    halted  = 1'b1;
                StIllegal: illegal = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic completing;
    always_comb begin
        completing = 1'b0;
        case (state_q)
            StAluwbR, StAluwbI, StMemwb, StMemwr, StBranch, StJump: completing = 1'b1;
            default: completing = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != StHalt && state_q != StIllegal) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (completing) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by cycle and
// compares the full output bundle against hand-derived per-state values.
module tb_mc_control_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       MWE, RFWE, PCE, IRWE, ID_sel, M_to_RF_sel, RFD_sel, halted, illegal;
    logic [3:0] ALU_sel;
    logic [1:0] ALU_in_sel1, ALU_in_sel2, PC_sel;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mc_control_fsm dut (
        .CLK         (CLK),
        .RST         (RST),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .MWE         (MWE),
        .RFWE        (RFWE),
        .PCE         (PCE),
        .IRWE        (IRWE),
        .ALU_sel     (ALU_sel),
        .ALU_in_sel1 (ALU_in_sel1),
        .ALU_in_sel2 (ALU_in_sel2),
        .PC_sel      (PC_sel),
        .ID_sel      (ID_sel),
        .M_to_RF_sel (M_to_RF_sel),
        .RFD_sel     (RFD_sel),
        .halted      (halted),
`ifdef CTRL_PERF_CNT_EN
        .illegal     (illegal),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`else
        .illegal     (illegal)
`endif
    );

    // Bundle layout: MWE RFWE PCE IRWE | ALU_sel | in1 | in2 | PC_sel | ID M2RF RFD halted illegal
    function automatic logic [18:0] mk(input logic mwe, input logic rfwe, input logic pce,
                                       input logic irwe, input logic [3:0] alu,
                                       input logic [1:0] i1, input logic [1:0] i2,
                                       input logic [1:0] ps, input logic id, input logic m2,
                                       input logic rfd, input logic h, input logic il);
        return {mwe, rfwe, pce, irwe, alu, i1, i2, ps, id, m2, rfd, h, il};
    endfunction

    wire [18:0] obs = {MWE, RFWE, PCE, IRWE, ALU_sel, ALU_in_sel1, ALU_in_sel2, PC_sel,
                       ID_sel, M_to_RF_sel, RFD_sel, halted, illegal};

    logic [18:0] e_zero, e_fetch, e_dec, e_rsub, e_rsll, e_wbr, e_itslt, e_wbi, e_madr;
    logic [18:0] e_mrd, e_mwb, e_mwr, e_br_t, e_br_nt, e_jump, e_halt, e_ill;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Check the current cycle just after the falling edge, then advance one cycle.
    task automatic cyc(input string tag, input logic [18:0] want);
        #1;
        chk(tag, {13'd0, obs}, {13'd0, want});
        @(negedge CLK);
    endtask

    initial begin
        e_zero  = mk(0,0,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0,0);
        e_fetch = mk(0,0,1,1, 4'd0, 2'd0, 2'd1, 2'd0, 0,0,0,0,0);
        e_dec   = mk(0,0,0,0, 4'd0, 2'd0, 2'd2, 2'd0, 0,0,0,0,0);
        e_rsub  = mk(0,0,0,0, 4'd1, 2'd1, 2'd0, 2'd0, 0,0,0,0,0);
        e_rsll  = mk(0,0,0,0, 4'd7, 2'd2, 2'd0, 2'd0, 0,0,0,0,0);
        e_wbr   = mk(0,1,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,1,0,0);
        e_itslt = mk(0,0,0,0, 4'd6, 2'd1, 2'd2, 2'd0, 0,0,0,0,0);
        e_wbi   = mk(0,1,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0,0);
        e_madr  = mk(0,0,0,0, 4'd0, 2'd1, 2'd2, 2'd0, 0,0,0,0,0);
        e_mrd   = mk(0,0,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 1,0,0,0,0);
        e_mwb   = mk(0,1,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 0,1,0,0,0);
        e_mwr   = mk(1,0,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 1,0,0,0,0);
        e_br_t  = mk(0,0,1,0, 4'd1, 2'd1, 2'd0, 2'd1, 0,0,0,0,0);
        e_br_nt = mk(0,0,0,0, 4'd1, 2'd1, 2'd0, 2'd1, 0,0,0,0,0);
        e_jump  = mk(0,0,1,0, 4'd0, 2'd0, 2'd0, 2'd2, 0,0,0,0,0);
        e_halt  = mk(0,0,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,1,0);
        e_ill   = mk(0,0,0,0, 4'd0, 2'd0, 2'd0, 2'd0, 0,0,0,0,1);

        RST = 1'b1; opcode = 6'h00; funct = 6'h22; zero = 1'b0;
        @(negedge CLK);
        cyc("reset0", e_zero);
        cyc("reset1", e_zero);
        RST = 1'b0;

        // R-type sub
        cyc("sub_fetch", e_fetch);
        cyc("sub_decode", e_dec);
        cyc("sub_rtype", e_rsub);
        cyc("sub_wb", e_wbr);

        // lw
        opcode = 6'h23;
        cyc("lw_fetch", e_fetch);
        cyc("lw_decode", e_dec);
        cyc("lw_memadr", e_madr);
        cyc("lw_memrd", e_mrd);
        cyc("lw_memwb", e_mwb);

        // sw: MWE for exactly one cycle
        opcode = 6'h2B;
        cyc("sw_fetch", e_fetch);
        cyc("sw_decode", e_dec);
        cyc("sw_memadr", e_madr);
        cyc("sw_memwr", e_mwr);

        // beq taken / not taken
        opcode = 6'h04; zero = 1'b1;
        cyc("sw_next_fetch", e_fetch);
        cyc("beq_t_decode", e_dec);
        cyc("beq_taken", e_br_t);
        zero = 1'b0;
        cyc("beq_nt_fetch", e_fetch);
        cyc("beq_nt_decode", e_dec);
        cyc("beq_not_taken", e_br_nt);

        // bne inverse polarity
        opcode = 6'h05;
        cyc("bne_t_fetch", e_fetch);
        cyc("bne_t_decode", e_dec);
        cyc("bne_taken", e_br_t);
        zero = 1'b1;
        cyc("bne_nt_fetch", e_fetch);
        cyc("bne_nt_decode", e_dec);
        cyc("bne_not_taken", e_br_nt);

        // j
        opcode = 6'h02; zero = 1'b0;
        cyc("j_fetch", e_fetch);
        cyc("j_decode", e_dec);
        cyc("j_jump", e_jump);

        // slti
        opcode = 6'h0A;
        cyc("slti_fetch", e_fetch);
        cyc("slti_decode", e_dec);
        cyc("slti_itype", e_itslt);
        cyc("slti_wb", e_wbi);

        // sll uses shamt on in1
        opcode = 6'h00; funct = 6'h00;
        cyc("sll_fetch", e_fetch);
        cyc("sll_decode", e_dec);
        cyc("sll_rtype", e_rsll);
        cyc("sll_wb", e_wbr);

        // unknown funct -> ILLEGAL after RTYPE
        funct = 6'h3F;
        cyc("badfn_fetch", e_fetch);
        cyc("badfn_decode", e_dec);
        @(negedge CLK);
        cyc("badfn_illegal", e_ill);
        cyc("badfn_stuck", e_ill);

        // reset recovers; then abort a store mid-MEMWR
        RST = 1'b1;
        cyc("rst_from_illegal", e_zero);
        RST = 1'b0; opcode = 6'h2B; funct = 6'h20;
        cyc("abort_fetch", e_fetch);
        cyc("abort_decode", e_dec);
        cyc("abort_memadr", e_madr);
        #1;
        chk("abort_memwr_pre", {13'd0, obs}, {13'd0, e_mwr});
        #1 RST = 1'b1;
        #1;
        chk("abort_memwr_masked", {13'd0, obs}, {13'd0, e_zero});
        @(negedge CLK);
        RST = 1'b0;
        cyc("abort_refetch", e_fetch);

        // undefined opcode 3E -> ILLEGAL
        opcode = 6'h3E;
        cyc("op3e_decode", e_dec);
        cyc("op3e_illegal", e_ill);
        RST = 1'b1;
        cyc("rst_again", e_zero);
        RST = 1'b0;

        // HALT opcode parks the FSM with no enables
        opcode = 6'h3F;
        cyc("halt_fetch", e_fetch);
        cyc("halt_decode", e_dec);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("halt_%0d", i), e_halt);
        end

`ifdef CTRL_PERF_CNT_EN
        // 3 R-type (4 cycles each) + lw (5 cycles) = 17 cycles, 4 instructions
        RST = 1'b1;
        @(negedge CLK);
        #1;
        chk("cnt_reset_cycle", cycle_cnt, 32'd0);
        chk("cnt_reset_instr", instr_cnt, 32'd0);
        RST = 1'b0; opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 12; i++) @(negedge CLK);
        opcode = 6'h23;
        for (int i = 0; i < 5; i++) @(negedge CLK);
        #1;
        chk("cnt_cycle", cycle_cnt, 32'd17);
        chk("cnt_instr", instr_cnt, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
